// File: rtl/iob_uart_fifo_pkg.sv
// Shared state encodings and constants for the iob_uart FIFO engine.
package iob_uart_fifo_pkg;

  localparam int MIN_BIT_DUR = 4;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/iob_uart_fifo_core_if.sv
// Register-file side of the UART engine: configuration, FIFO strobes and status.
interface iob_uart_fifo_core_if #(
  parameter int DATA_W  = 8,
  parameter int DIV_W   = 16,
  parameter int FIFO_AW = 4
);
  logic               rst_soft_i;
  logic               tx_en_i;
  logic               rx_en_i;
  logic [DIV_W-1:0]   bit_duration_i;
  logic               parity_en_i;
  logic               parity_odd_i;
  logic               stop2_i;
  logic [DATA_W-1:0]  tx_data_i;
  logic               tx_push_i;
  logic               tx_full_o;
  logic [FIFO_AW:0]   tx_level_o;
  logic               tx_idle_o;
  logic [DATA_W-1:0]  rx_data_o;
  logic               rx_pop_i;
  logic               rx_empty_o;
  logic [FIFO_AW:0]   rx_level_o;
  logic               rx_overrun_o;
  logic               rx_frame_err_o;
  logic               rx_parity_err_o;
  logic               err_clr_i;

  modport master (
    output rst_soft_i, tx_en_i, rx_en_i, bit_duration_i, parity_en_i, parity_odd_i,
           stop2_i, tx_data_i, tx_push_i, rx_pop_i, err_clr_i,
    input  tx_full_o, tx_level_o, tx_idle_o, rx_data_o, rx_empty_o, rx_level_o,
           rx_overrun_o, rx_frame_err_o, rx_parity_err_o
  );

  modport slave (
    input  rst_soft_i, tx_en_i, rx_en_i, bit_duration_i, parity_en_i, parity_odd_i,
           stop2_i, tx_data_i, tx_push_i, rx_pop_i, err_clr_i,
    output tx_full_o, tx_level_o, tx_idle_o, rx_data_o, rx_empty_o, rx_level_o,
           rx_overrun_o, rx_frame_err_o, rx_parity_err_o
  );
endinterface

// File: rtl/iob_uart_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy output; head reads as 0 when empty.
module iob_uart_sync_fifo #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [FIFO_AW:0]  o_level
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_level == LVL_FULL);
  assign o_empty = (r_level == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_level = r_level;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/iob_uart_fifo_core.sv
// UART engine with TX/RX FIFOs, runtime bit divider, parity and stop-bit select.
// Parity generation/checking is built only when IOB_UART_PARITY_EN is defined.
module iob_uart_fifo_core
  import iob_uart_fifo_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_AW    = 4,
  parameter int RTS_MARGIN = 2
) (
  input  logic clk_i,
  input  logic arst_i,
  iob_uart_fifo_core_if.slave bus,
  input  logic rxd_i,
  output logic txd_o,
  input  logic cts_i,
  output logic rts_o
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] RTS_THR  = (FIFO_AW+1)'(DEPTH - RTS_MARGIN);
  localparam logic [DIV_W-1:0] BD_MIN   = DIV_W'(MIN_BIT_DUR);
  localparam logic [3:0]       LAST_BIT = 4'(DATA_W - 1);

  logic [DIV_W-1:0] w_bd_eff;
  logic             w_par_en;
  logic             w_par_odd;

  assign w_bd_eff = (bus.bit_duration_i < BD_MIN) ? BD_MIN : bus.bit_duration_i;

`ifdef IOB_UART_PARITY_EN
  assign w_par_en  = bus.parity_en_i;
  assign w_par_odd = bus.parity_odd_i;
`else
  logic w_unused_par;
  assign w_unused_par = bus.parity_en_i ^ bus.parity_odd_i;
  assign w_par_en     = 1'b0;
  assign w_par_odd    = 1'b0;
`endif

  // ---------------- transmitter ----------------
  tx_state_t         r_tx_state, w_tx_next;
  logic [DATA_W-1:0] w_tx_head, r_tx_shift;
  logic [DIV_W-1:0]  r_tx_cnt, r_tx_bd;
  logic [3:0]        r_tx_idx;
  logic              r_tx_par, r_tx_par_en, r_tx_stop2, r_tx_stop_2nd;
  logic              r_txd, w_txd_next, w_tx_empty, w_tx_start, w_tx_tick;

  iob_uart_sync_fifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) u_tx_fifo (
    .clk_i(clk_i), .arst_i(arst_i), .i_clr(bus.rst_soft_i),
    .i_push(bus.tx_push_i), .i_data(bus.tx_data_i), .i_pop(w_tx_start),
    .o_data(w_tx_head), .o_full(bus.tx_full_o), .o_empty(w_tx_empty),
    .o_level(bus.tx_level_o)
  );

  assign w_tx_tick     = (r_tx_state != TX_IDLE) && (r_tx_cnt == '0);
  assign bus.tx_idle_o = w_tx_empty && (r_tx_state == TX_IDLE);
  assign txd_o         = r_txd;

  always_comb begin
    w_tx_next  = r_tx_state;
    w_tx_start = 1'b0;
    w_txd_next = 1'b1;
    case (r_tx_state)
      TX_IDLE: if (!w_tx_empty && bus.tx_en_i && cts_i) begin
        w_tx_next  = TX_START;
        w_tx_start = 1'b1;
      end
      TX_START: begin
        w_txd_next = 1'b0;
        if (w_tx_tick) w_tx_next = TX_DATA;
      end
      TX_DATA: begin
        w_txd_next = r_tx_shift[0];
        if (w_tx_tick && r_tx_idx == LAST_BIT) w_tx_next = r_tx_par_en ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        w_txd_next = r_tx_par;
        if (w_tx_tick) w_tx_next = TX_STOP;
      end
      TX_STOP: if (w_tx_tick && (!r_tx_stop2 || r_tx_stop_2nd)) w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // txd is registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_tx_state <= TX_IDLE;  r_txd <= 1'b1;       r_tx_cnt <= '0;     r_tx_bd <= '0;
      r_tx_shift <= '0;       r_tx_idx <= '0;      r_tx_par <= 1'b0;   r_tx_par_en <= 1'b0;
      r_tx_stop2 <= 1'b0;     r_tx_stop_2nd <= 1'b0;
    end else if (bus.rst_soft_i) begin
      r_tx_state <= TX_IDLE;  r_txd <= 1'b1;       r_tx_cnt <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      r_txd      <= w_txd_next;
      if (w_tx_start) begin
        r_tx_cnt      <= w_bd_eff - 1'b1;
        r_tx_bd       <= w_bd_eff;
        r_tx_shift    <= w_tx_head;
        r_tx_idx      <= '0;
        r_tx_par      <= (^w_tx_head) ^ w_par_odd;
        r_tx_par_en   <= w_par_en;
        r_tx_stop2    <= bus.stop2_i;
        r_tx_stop_2nd <= 1'b0;
      end else if (r_tx_state != TX_IDLE) begin
        if (w_tx_tick) begin
          r_tx_cnt <= r_tx_bd - 1'b1;
          if (r_tx_state == TX_DATA) begin
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_idx   <= r_tx_idx + 1'b1;
          end
          if (r_tx_state == TX_STOP) r_tx_stop_2nd <= 1'b1;
        end else begin
          r_tx_cnt <= r_tx_cnt - 1'b1;
        end
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t          r_rx_state, w_rx_next;
  logic [SYNC_STAGES-1:0] r_rxd_sync;
  logic [DATA_W-1:0]  r_rx_shift;
  logic [DIV_W-1:0]   r_rx_cnt, r_rx_bd;
  logic [3:0]         r_rx_idx;
  logic               r_rxd_prev, r_rx_par_bit, r_rx_par_en, r_rx_odd;
  logic               w_rxd_s, w_rx_fall, w_rx_begin, w_rx_tick, w_rx_done, w_rx_full;
  logic               w_rx_push, w_frame_set, w_par_set, w_ovr_set;
  logic               r_ovr, r_frame_err, r_par_err, r_rts;

  assign w_rxd_s   = r_rxd_sync[SYNC_STAGES-1];
  assign w_rx_fall = r_rxd_prev & ~w_rxd_s;
  assign w_rx_tick = (r_rx_state != RX_IDLE) && (r_rx_cnt == '0);

  always_comb begin
    w_rx_next  = r_rx_state;
    w_rx_begin = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (bus.rx_en_i && w_rx_fall) begin
        w_rx_next  = RX_START;
        w_rx_begin = 1'b1;
      end
      RX_START:  if (w_rx_tick) w_rx_next = w_rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_rx_tick && r_rx_idx == LAST_BIT) w_rx_next = r_rx_par_en ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_rx_tick) w_rx_next = RX_STOP;
      RX_STOP:   if (w_rx_tick) w_rx_next = RX_IDLE;
      default:   w_rx_next = RX_IDLE;
    endcase
    if (r_rx_state != RX_IDLE && !bus.rx_en_i) w_rx_next = RX_IDLE;
  end

  // Stop-bit errors take precedence over parity; only clean words reach the FIFO.
  assign w_rx_done   = (r_rx_state == RX_STOP) && w_rx_tick && bus.rx_en_i;
  assign w_frame_set = w_rx_done && !w_rxd_s;
  assign w_par_set   = w_rx_done && w_rxd_s && r_rx_par_en &&
                       (r_rx_par_bit != ((^r_rx_shift) ^ r_rx_odd));
  assign w_rx_push   = w_rx_done && w_rxd_s && !w_par_set;
  assign w_ovr_set   = w_rx_push && w_rx_full;

  iob_uart_sync_fifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) u_rx_fifo (
    .clk_i(clk_i), .arst_i(arst_i), .i_clr(bus.rst_soft_i),
    .i_push(w_rx_push), .i_data(r_rx_shift), .i_pop(bus.rx_pop_i),
    .o_data(bus.rx_data_o), .o_full(w_rx_full), .o_empty(bus.rx_empty_o),
    .o_level(bus.rx_level_o)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_rxd_sync <= '1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_sync <= {r_rxd_sync[SYNC_STAGES-2:0], rxd_i};
      r_rxd_prev <= w_rxd_s;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_rx_state <= RX_IDLE;  r_rx_cnt <= '0;   r_rx_bd <= '0;        r_rx_shift <= '0;
      r_rx_idx <= '0;         r_rx_par_bit <= 1'b0; r_rx_par_en <= 1'b0; r_rx_odd <= 1'b0;
    end else if (bus.rst_soft_i) begin
      r_rx_state <= RX_IDLE;  r_rx_cnt <= '0;
    end else begin
      r_rx_state <= w_rx_next;
      if (w_rx_begin) begin
        r_rx_cnt    <= (w_bd_eff >> 1) - 1'b1;
        r_rx_bd     <= w_bd_eff;
        r_rx_idx    <= '0;
        r_rx_par_en <= w_par_en;
        r_rx_odd    <= w_par_odd;
      end else if (r_rx_state != RX_IDLE) begin
        if (w_rx_tick) begin
          r_rx_cnt <= r_rx_bd - 1'b1;
          if (r_rx_state == RX_DATA) begin
            r_rx_shift <= {w_rxd_s, r_rx_shift[DATA_W-1:1]};
            r_rx_idx   <= r_rx_idx + 1'b1;
          end
          if (r_rx_state == RX_PARITY) r_rx_par_bit <= w_rxd_s;
        end else begin
          r_rx_cnt <= r_rx_cnt - 1'b1;
        end
      end
    end
  end

  // A set event in the same cycle as err_clr_i keeps the flag set.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_ovr <= 1'b0;  r_frame_err <= 1'b0;  r_par_err <= 1'b0;  r_rts <= 1'b0;
    end else if (bus.rst_soft_i) begin
      r_ovr <= 1'b0;  r_frame_err <= 1'b0;  r_par_err <= 1'b0;  r_rts <= 1'b0;
    end else begin
      r_ovr       <= w_ovr_set   | (r_ovr       & ~bus.err_clr_i);
      r_frame_err <= w_frame_set | (r_frame_err & ~bus.err_clr_i);
      r_par_err   <= w_par_set   | (r_par_err   & ~bus.err_clr_i);
      r_rts       <= bus.rx_en_i & (bus.rx_level_o <= RTS_THR);
    end
  end

  assign bus.rx_overrun_o    = r_ovr;
  assign bus.rx_frame_err_o  = r_frame_err;
  assign bus.rx_parity_err_o = r_par_err;
  assign rts_o               = r_rts;
endmodule

// File: tb/tb_iob_uart_fifo_core.sv
// Directed bench for iob_uart_fifo_core (DATA_W=8, FIFO_AW=2, RTS_MARGIN=2).
// Parity expectations follow whether IOB_UART_PARITY_EN is defined for the build.
module tb_iob_uart_fifo_core;
  localparam int BD = 16;

  logic clk_i = 1'b0;
  logic arst_i;
  logic rxd_drv, loop_en, w_rxd, txd_o, cts_i, rts_o;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  iob_uart_fifo_core_if #(.DATA_W(8), .DIV_W(16), .FIFO_AW(2)) u_if ();

  assign w_rxd = loop_en ? txd_o : rxd_drv;

  iob_uart_fifo_core #(.DATA_W(8), .DIV_W(16), .FIFO_AW(2), .RTS_MARGIN(2)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .bus(u_if.slave),
    .rxd_i(w_rxd), .txd_o(txd_o), .cts_i(cts_i), .rts_o(rts_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic with_par,
                            input logic par_bit, input logic stop_bit);
    rxd_drv = 1'b0;
    repeat (BD) step();
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      repeat (BD) step();
    end
    if (with_par) begin
      rxd_drv = par_bit;
      repeat (BD) step();
    end
    rxd_drv = stop_bit;
    repeat (BD) step();
    rxd_drv = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_reset();
    arst_i = 1'b1;
    u_if.rst_soft_i = 1'b0;  u_if.tx_en_i = 1'b1;  u_if.rx_en_i = 1'b1;
    u_if.bit_duration_i = 16'(BD);  u_if.parity_en_i = 1'b0;  u_if.parity_odd_i = 1'b0;
    u_if.stop2_i = 1'b0;  u_if.tx_data_i = 8'h00;  u_if.tx_push_i = 1'b0;
    u_if.rx_pop_i = 1'b0;  u_if.err_clr_i = 1'b0;
    cts_i = 1'b1;  rxd_drv = 1'b1;  loop_en = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({txd_o, rts_o, u_if.tx_full_o, u_if.tx_idle_o, u_if.rx_empty_o} !== 5'b10011) begin
      n_err++;
      $display("FAIL reset_pins: got txd/rts/full/idle/empty=%b expected 10011",
               {txd_o, rts_o, u_if.tx_full_o, u_if.tx_idle_o, u_if.rx_empty_o});
    end
    n_cmp++;
    if ({u_if.tx_level_o, u_if.rx_level_o, u_if.rx_data_o} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_levels: got txlvl=%0d rxlvl=%0d rxdata=%h expected 0/0/00",
               u_if.tx_level_o, u_if.rx_level_o, u_if.rx_data_o);
    end
    n_cmp++;
    if ({u_if.rx_overrun_o, u_if.rx_frame_err_o, u_if.rx_parity_err_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 000",
               {u_if.rx_overrun_o, u_if.rx_frame_err_o, u_if.rx_parity_err_o});
    end
    arst_i = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_tx_frame();
    logic [9:0] exp_line;
    exp_line = {1'b1, 8'hA5, 1'b0};
    u_if.tx_data_i = 8'hA5;  u_if.tx_push_i = 1'b1;
    step();
    u_if.tx_push_i = 1'b0;
    step();
    n_cmp++;
    if (txd_o !== 1'b1) begin
      n_err++; $display("FAIL tx_start_early: got txd=%b expected 1 one cycle after push edge", txd_o);
    end
    step();
    n_cmp++;
    if (txd_o !== 1'b0) begin
      n_err++; $display("FAIL tx_start_latency: got txd=%b expected 0 two cycles after push edge", txd_o);
    end
    repeat (8) step();
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (txd_o !== exp_line[k]) begin
        n_err++; $display("FAIL tx_bit%0d: got %b expected %b", k, txd_o, exp_line[k]);
      end
      if (k < 9) repeat (BD) step();
    end
    repeat (6) step();
    n_cmp++;
    if (u_if.tx_idle_o !== 1'b0) begin
      n_err++; $display("FAIL tx_idle_early: got %b expected 0 at 159 cycles", u_if.tx_idle_o);
    end
    step();
    n_cmp++;
    if (u_if.tx_idle_o !== 1'b1) begin
      n_err++; $display("FAIL tx_idle_end: got %b expected 1 at 160 cycles", u_if.tx_idle_o);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] exp_w [3];
    int t;
    exp_w[0] = 8'h00;  exp_w[1] = 8'hFF;  exp_w[2] = 8'h3C;
    loop_en = 1'b1;  u_if.parity_en_i = 1'b1;  u_if.parity_odd_i = 1'b0;  u_if.stop2_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      u_if.tx_data_i = exp_w[i];  u_if.tx_push_i = 1'b1;
      step();
    end
    u_if.tx_push_i = 1'b0;
    t = 0;
    while (u_if.rx_level_o !== 3'd3 && t < 1500) begin
      step(); t++;
    end
    n_cmp++;
    if (u_if.rx_level_o !== 3'd3) begin
      n_err++; $display("FAIL loop_level: got %0d expected 3 (timeout)", u_if.rx_level_o);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (u_if.rx_data_o !== exp_w[i]) begin
        n_err++; $display("FAIL loop_word%0d: got %h expected %h", i, u_if.rx_data_o, exp_w[i]);
      end
      u_if.rx_pop_i = 1'b1;
      step();
      u_if.rx_pop_i = 1'b0;
    end
    n_cmp++;
    if ({u_if.rx_empty_o, u_if.rx_overrun_o, u_if.rx_frame_err_o, u_if.rx_parity_err_o} !== 4'b1000) begin
      n_err++;
      $display("FAIL loop_flags: got empty/ovr/frm/par=%b expected 1000",
               {u_if.rx_empty_o, u_if.rx_overrun_o, u_if.rx_frame_err_o, u_if.rx_parity_err_o});
    end
    t = 0;
    while (u_if.tx_idle_o !== 1'b1 && t < 400) begin
      step(); t++;
    end
    step();
    loop_en = 1'b0;  u_if.parity_en_i = 1'b0;  u_if.stop2_i = 1'b0;
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({u_if.rx_frame_err_o, u_if.rx_level_o} !== 4'b1_000) begin
      n_err++;
      $display("FAIL frame_err_set: got flag=%b level=%0d expected 1/0", u_if.rx_frame_err_o, u_if.rx_level_o);
    end
    u_if.err_clr_i = 1'b1;
    step();
    u_if.err_clr_i = 1'b0;
    n_cmp++;
    if (u_if.rx_frame_err_o !== 1'b0) begin
      n_err++; $display("FAIL frame_err_clr: got %b expected 0", u_if.rx_frame_err_o);
    end
  endtask

  task automatic test_parity();
    u_if.parity_en_i = 1'b1;  u_if.parity_odd_i = 1'b1;
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
`ifdef IOB_UART_PARITY_EN
    n_cmp++;
    if ({u_if.rx_parity_err_o, u_if.rx_level_o} !== 4'b1_000) begin
      n_err++;
      $display("FAIL parity_err: got flag=%b level=%0d expected 1/0", u_if.rx_parity_err_o, u_if.rx_level_o);
    end
`else
    n_cmp++;
    if ({u_if.rx_parity_err_o, u_if.rx_level_o, u_if.rx_data_o} !== 12'b0_001_00000001) begin
      n_err++;
      $display("FAIL parity_ignored: got flag=%b level=%0d data=%h expected 0/1/01",
               u_if.rx_parity_err_o, u_if.rx_level_o, u_if.rx_data_o);
    end
    u_if.rx_pop_i = 1'b1;
    step();
    u_if.rx_pop_i = 1'b0;
`endif
    u_if.err_clr_i = 1'b1;
    step();
    u_if.err_clr_i = 1'b0;
    u_if.parity_en_i = 1'b0;  u_if.parity_odd_i = 1'b0;
    step();
  endtask

  task automatic test_rts_overrun();
    logic [2:0] exp_lvl;
    n_cmp++;
    if (rts_o !== 1'b1) begin
      n_err++; $display("FAIL rts_initial: got %b expected 1", rts_o);
    end
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
      exp_lvl = (i < 3) ? 3'(i + 1) : 3'd4;
      n_cmp++;
      if ({u_if.rx_level_o, rts_o, u_if.rx_overrun_o} !== {exp_lvl, (exp_lvl <= 3'd2), (i == 4)}) begin
        n_err++;
        $display("FAIL rts_frame%0d: got level=%0d rts=%b ovr=%b expected %0d/%b/%b", i + 1,
                 u_if.rx_level_o, rts_o, u_if.rx_overrun_o, exp_lvl, (exp_lvl <= 3'd2), (i == 4));
      end
    end
    n_cmp++;
    if (u_if.rx_data_o !== 8'h10) begin
      n_err++; $display("FAIL rx_head: got %h expected 10", u_if.rx_data_o);
    end
    u_if.rst_soft_i = 1'b1;
    step();
    u_if.rst_soft_i = 1'b0;
    n_cmp++;
    if ({u_if.rx_level_o, u_if.rx_empty_o, u_if.rx_data_o, u_if.rx_overrun_o, rts_o} !== {3'd0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL soft_rx: got level=%0d empty=%b data=%h ovr=%b rts=%b expected 0/1/00/0/0",
               u_if.rx_level_o, u_if.rx_empty_o, u_if.rx_data_o, u_if.rx_overrun_o, rts_o);
    end
    u_if.rx_pop_i = 1'b1;
    step();
    u_if.rx_pop_i = 1'b0;
    n_cmp++;
    if ({u_if.rx_level_o, u_if.rx_empty_o} !== 4'b000_1) begin
      n_err++; $display("FAIL pop_empty: got level=%0d empty=%b expected 0/1", u_if.rx_level_o, u_if.rx_empty_o);
    end
  endtask

  task automatic test_cts_soft_reset();
    int bad;
    cts_i = 1'b0;  u_if.tx_data_i = 8'h00;
    u_if.tx_push_i = 1'b1;
    repeat (5) step();
    u_if.tx_push_i = 1'b0;
    n_cmp++;
    if ({u_if.tx_level_o, u_if.tx_full_o} !== 4'b100_1) begin
      n_err++; $display("FAIL tx_full: got level=%0d full=%b expected 4/1", u_if.tx_level_o, u_if.tx_full_o);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (txd_o !== 1'b1) bad++;
      step();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL cts_hold: got %0d low cycles expected 0", bad);
    end
    cts_i = 1'b1;
    repeat (2) step();
    n_cmp++;
    if ({txd_o, u_if.tx_level_o} !== 4'b0_011) begin
      n_err++; $display("FAIL cts_start: got txd=%b level=%0d expected 0/3", txd_o, u_if.tx_level_o);
    end
    repeat (40) step();
    n_cmp++;
    if (txd_o !== 1'b0) begin
      n_err++; $display("FAIL mid_frame: got txd=%b expected 0", txd_o);
    end
    u_if.rst_soft_i = 1'b1;
    step();
    u_if.rst_soft_i = 1'b0;
    n_cmp++;
    if ({txd_o, u_if.tx_level_o, u_if.tx_idle_o, u_if.tx_full_o} !== 6'b1_000_1_0) begin
      n_err++;
      $display("FAIL soft_tx: got txd=%b level=%0d idle=%b full=%b expected 1/0/1/0",
               txd_o, u_if.tx_level_o, u_if.tx_idle_o, u_if.tx_full_o);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (txd_o !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL soft_tx_quiet: got %0d low cycles expected 0", bad);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_frame_err();
    test_parity();
    test_rts_overrun();
    test_cts_soft_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/iob_uart_fifo_core.md
Name: iob_uart_fifo_core

Overview:
Next-generation UART engine for the iob_uart peripheral. It adds parametrised data width and per-direction FIFOs, plus runtime-selectable parity and stop-bit count. The bit clock comes from a runtime divider. The block sits behind the iob_uart software register file, which drives its configuration and FIFO push/pop strobes; serial pins go to the chip pads.

Parameters:
DATA_W, 8, payload bits per frame (5..9), LSB first on the line
DIV_W, 16, width of bit_duration_i
FIFO_AW, 4, log2 of each FIFO depth (DEPTH = 2**FIFO_AW)
RTS_MARGIN, 2, free RX entries required to keep rts_o asserted

Ports:
clk_i  input  1  system clock
arst_i  input  1  asynchronous active-high reset
rst_soft_i  input  1  synchronous soft reset; clears FIFOs, FSMs and flags
tx_en_i  input  1  transmitter enable
rx_en_i  input  1  receiver enable
bit_duration_i  input  DIV_W  clk_i cycles per bit; values below 4 are treated as 4
parity_en_i  input  1  append/check parity bit
parity_odd_i  input  1  1 = odd parity, 0 = even
stop2_i  input  1  1 = two stop bits, 0 = one
tx_data_i  input  DATA_W  word to enqueue
tx_push_i  input  1  enqueue strobe
tx_full_o  output  1  TX FIFO full
tx_level_o  output  FIFO_AW+1  TX FIFO occupancy
tx_idle_o  output  1  TX FIFO empty and serializer idle
rx_data_o  output  DATA_W  head of RX FIFO (show-ahead)
rx_pop_i  input  1  dequeue strobe
rx_empty_o  output  1  RX FIFO empty
rx_level_o  output  FIFO_AW+1  RX FIFO occupancy
rx_overrun_o  output  1  sticky: received word dropped, FIFO full
rx_frame_err_o  output  1  sticky: stop bit sampled low
rx_parity_err_o  output  1  sticky: parity mismatch
err_clr_i  input  1  clears the three sticky flags
rxd_i  input  1  serial input (asynchronous)
txd_o  output  1  serial output
cts_i  input  1  clear-to-send from peer, active high
rts_o  output  1  request-to-send to peer, active high

Behaviour:
- Reset values (arst_i, or rst_soft_i at the next edge): txd_o=1, rts_o=0, tx_full_o=0, tx_idle_o=1, rx_empty_o=1, levels=0, rx_data_o=0, sticky flags=0, both FSMs in IDLE.
- FIFOs:
  - Push when full is ignored, even if a pop occurs in the same cycle. Pop when empty is ignored.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the level unchanged.
  - Pointers wrap modulo DEPTH. Levels update the cycle after the strobe.
- TX FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - PARITY is skipped if parity_en_i=0.
  - STOP lasts 1 or 2 bit times per stop2_i.
  - Each bit holds txd_o for exactly bit_duration_i cycles.
  - IDLE leaves only when the FIFO is non-empty, tx_en_i=1 and cts_i=1; these are sampled in IDLE only.
  - With the FSM idle and enabled, txd_o falls exactly 2 cycles after the tx_push_i edge.
  - Configuration inputs are latched at START.
  - Deasserting tx_en_i or cts_i mid-frame has no effect on the current frame; the next frame is held.
- Parity bit: XOR of the DATA_W data bits, inverted when parity_odd_i=1.
- RX path:
  - rxd_i passes through a 2-flop synchronizer (2 cycles latency).
  - IDLE -> START on a synchronized falling edge while rx_en_i=1.
  - At floor(bit_duration_i/2) cycles the start bit is re-sampled. If high: false start, back to IDLE, nothing stored.
  - Otherwise, DATA, PARITY and STOP are each sampled once at mid-bit, every bit_duration_i cycles. Only the first stop bit is checked.
- RX word completion (at the stop sample):
  - Stop bit low: rx_frame_err_o set, word discarded.
  - Parity mismatch: rx_parity_err_o set, word discarded.
  - Otherwise the word is pushed. If the FIFO is full, the word is dropped and rx_overrun_o is set.
  - After the stop sample the FSM returns to IDLE, so back-to-back frames are accepted.
- Sticky flags: a flag-set event in the same cycle as err_clr_i wins.
- rx_en_i deasserted mid-frame: the RX FSM returns to IDLE next cycle and the partial word is discarded.
- rts_o = rx_en_i & (rx_level_o <= DEPTH-RTS_MARGIN), registered (1 cycle latency).

Optional Feature:
IOB_UART_PARITY_EN.
- Defined: parity generation and checking as above.
- Undefined: parity_en_i and parity_odd_i stay on the port list but are ignored, PARITY states are never entered, and rx_parity_err_o is tied to 0.

Decomposition:
- Package iob_uart_fifo_pkg: TX/RX state encodings, the minimum bit duration constant (4), the synchronizer depth (2).
- One sub-module, iob_uart_sync_fifo (parameters DATA_W, FIFO_AW; show-ahead output; level output), instantiated twice.
- Serializer and deserializer FSMs stay in the top module.

Test Plan:
- DATA_W=8, bit_duration_i=16, parity off, 1 stop; push 0xA5 -> txd_o low 2 cycles after push; line sequence 0,1,0,1,0,0,1,0,1,1 at 16 cycles per bit; tx_idle_o=1 after 160 cycles.
- Loopback txd_o->rxd_i, parity even, stop2_i=1; push 0x00, 0xFF, 0x3C -> rx_level_o=3, words popped in order; no flags set.
- Drive a frame with the stop bit low -> rx_frame_err_o=1, rx_level_o unchanged; err_clr_i pulse -> flag 0.
- Define IOB_UART_PARITY_EN, odd parity; send 0x01 with parity bit 1 -> rx_parity_err_o=1, word discarded; same stimulus without the macro -> word stored, flag 0.
- FIFO_AW=2, RTS_MARGIN=2; receive 5 frames without popping -> rts_o drops after the 3rd word; 5th word dropped, rx_overrun_o=1, rx_level_o=4.
- cts_i=0 with 2 words queued -> txd_o stays 1; raise cts_i -> start bit within 2 cycles. Then assert rst_soft_i mid-frame -> txd_o=1 and tx_level_o=0 next cycle.
